rgb_cycle_monitor: RTL

Receive-side checker for the active-low RGB LED color cycle (RED, YELLOW, GREEN, CYAN, BLUE, MAGENTA, repeat). It samples the three LED drive lines, synchronizes and deglitches them, and decodes the current color. It then checks that every color change follows the cycle order and that each color holds for the programmed interval. It sits beside the LED driver, or on a second board wired to the LED pins, for self-test and bring-up.

---
 rtl/rgb_cycle_monitor.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/rgb_cycle_monitor.sv
// Receive-side checker for the active-low RGB LED colour cycle: synchronises,
// deglitches and decodes the LED lines, then checks transition order and dwell.
module rgb_cycle_monitor #(
    parameter int FADE_INTERVAL = 2000000,
    parameter int TOLERANCE     = 16,
    parameter int STABLE_CYCLES = 4,
    localparam int DW           = $clog2(FADE_INTERVAL + TOLERANCE + 1) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          RGB_R,
    input  logic          RGB_G,
    input  logic          RGB_B,
    output logic [2:0]    color,
    output logic          color_valid,
    output logic          locked,
    output logic          seq_err,
    output logic          timing_err,
    output logic [DW-1:0] dwell_last,
    output logic [7:0]    err_count
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    localparam logic [2:0] C_RED     = 3'd0;
    localparam logic [2:0] C_YELLOW  = 3'd1;
    localparam logic [2:0] C_GREEN   = 3'd2;
    localparam logic [2:0] C_CYAN    = 3'd3;
    localparam logic [2:0] C_BLUE    = 3'd4;
    localparam logic [2:0] C_MAGENTA = 3'd5;
    localparam logic [2:0] C_INVALID = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic [2:0] decode(input logic [2:0] rgb);
        logic [2:0] c;
        case (rgb)
            3'b011:  c = C_RED;
            3'b001:  c = C_YELLOW;
            3'b101:  c = C_GREEN;
            3'b100:  c = C_CYAN;
            3'b110:  c = C_BLUE;
            3'b010:  c = C_MAGENTA;
            default: c = C_INVALID;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] succ(input logic [2:0] c);
        return (c == C_MAGENTA) ? C_RED : c + 3'd1;
    endfunction

    function automatic logic [DW-1:0] sat_inc_dw(input logic [DW-1:0] v);
        return (v == {DW{1'b1}}) ? v : v + DW'(1);
    endfunction

    function automatic logic [7:0] sat_inc_err(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic in_tolerance(input logic [DW-1:0] d);
        longint dv;
        dv = longint'(d);
        return (dv >= longint'(FADE_INTERVAL) - longint'(TOLERANCE)) &&
               (dv <= longint'(FADE_INTERVAL) + longint'(TOLERANCE));
    endfunction

    // Stage p0/p1: two-flop synchroniser, idle level is LED off
    logic [2:0] sync_p0, sync_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 3'b111;
            sync_p1 <= 3'b111;
        end else begin
            sync_p0 <= {RGB_R, RGB_G, RGB_B};
            sync_p1 <= sync_p0;
        end
    end

    logic [2:0] dec_p1;
    assign dec_p1 = decode(sync_p1);

    // Stage p2: deglitch filter; the count holds at STABLE_CYCLES once reached
    logic [2:0]    cand_p2;
    logic [CW-1:0] match_cnt_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_p2      <= C_INVALID;
            match_cnt_p2 <= '0;
        end else if (dec_p1 != cand_p2) begin
            cand_p2      <= dec_p1;
            match_cnt_p2 <= CW'(1);
        end else if (match_cnt_p2 != CW'(STABLE_CYCLES)) begin
            match_cnt_p2 <= match_cnt_p2 + CW'(1);
        end
    end

    logic accept;
    assign accept = (match_cnt_p2 == CW'(STABLE_CYCLES)) && (cand_p2 != color);

    // Restarting at 1 makes the value held at the next accept equal the hold time
    logic [DW-1:0] dwell_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_cnt  <= '0;
            dwell_last <= '0;
        end else if (accept) begin
            dwell_cnt  <= DW'(1);
            dwell_last <= dwell_cnt;
        end else begin
            dwell_cnt  <= sat_inc_dw(dwell_cnt);
        end
    end

    state_t     state, state_n;
    logic [2:0] color_n;
    logic       seq_n, tim_n;

    always_comb begin
        state_n = state;
        color_n = color;
        seq_n   = 1'b0;
        tim_n   = 1'b0;
        if (accept) begin
            color_n = cand_p2;
            case (state)
                IDLE: begin
                    if (cand_p2 != C_INVALID) state_n = ACQUIRE;
                end
                ACQUIRE: begin
                    if (cand_p2 == C_INVALID)
                        state_n = IDLE;
                    else if (cand_p2 == succ(color))
                        state_n = LOCKED;
                end
                LOCKED: begin
                    if (cand_p2 == C_INVALID) begin
                        seq_n   = 1'b1;
                        state_n = IDLE;
                    end else if (cand_p2 == succ(color)) begin
                        // an out-of-order event never reaches here, so seq wins
                        tim_n   = !in_tolerance(dwell_cnt);
                    end else begin
                        seq_n   = 1'b1;
                        state_n = ACQUIRE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            color       <= C_INVALID;
            color_valid <= 1'b0;
            locked      <= 1'b0;
            seq_err     <= 1'b0;
            timing_err  <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            state       <= state_n;
            color       <= color_n;
            color_valid <= (color_n != C_INVALID);
            locked      <= (state_n == LOCKED);
            seq_err     <= seq_n;
            timing_err  <= tim_n;
            if (seq_n || tim_n) err_count <= sat_inc_err(err_count);
        end
    end

endmodule
